// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Writeback arbiter feeding the single register file write port. Two result
// streams compete for that port every cycle:
//   * single-cycle ALU results, which win by default, and
//   * variable-latency load results, which wait in a 2-entry FIFO until the
//     ALU is idle or until they have lost arbitration STARVE_LIMIT times in
//     a row, at which point the FIFO head is forced through.
// The winning result is registered onto rf_we/rf_wa/rf_wd so the register
// file, which captures on the falling edge, sees stable values.
//
// An optional pending-load scoreboard tracks which registers still have a
// load in flight, so the decode hazard unit can stall dependent
// instructions. It is built only when the macro WB_ARBITER_SCOREBOARD_EN is
// defined. Without it, busy is tied to 0, iss_valid/iss_rd are ignored and
// decode is expected to stall on every load.
//
// Parameters:
//   STARVE_LIMIT  consecutive lost arbitrations before a load is forced (>= 1)
//   XLEN          result data width
//
// Ports:
//   clk        in   core clock, all state updates on the rising edge
//   rst_n      in   synchronous active-low reset
//   alu_valid  in   ALU result present
//   alu_ready  out  ALU result accepted this cycle
//   alu_rd     in   ALU destination register
//   alu_data   in   ALU result
//   ld_valid   in   load result present
//   ld_ready   out  load FIFO can accept an entry
//   ld_rd      in   load destination register
//   ld_data    in   load data
//   iss_valid  in   load issued to memory this cycle
//   iss_rd     in   issued load's destination register
//   rf_we      out  register file write enable (registered)
//   rf_wa      out  register file write address (registered)
//   rf_wd      out  register file write data (registered)
//   busy       out  per-register pending-load flags, bit 0 always 0
// ---------------------------------------------------------------------------
module wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [4:0]      ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd,
    output logic [31:0]     busy
);

    // Wide enough to hold the value STARVE_LIMIT itself.
    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    // Load FIFO storage and bookkeeping.
    logic [4:0]      fifo_rd   [2];
    logic [XLEN-1:0] fifo_data [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;

    logic [STARVE_W-1:0] starve_cnt;

    logic            fifo_empty;
    logic            fifo_full;
    logic            force_ld;
    logic            alu_fire;
    logic            ld_push;
    logic            ld_pop;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;

    assign fifo_empty = (count == 2'd0);
    assign fifo_full  = (count == 2'd2);
    assign head_rd    = fifo_rd[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];

    // Once the waiting head has lost STARVE_LIMIT times it takes the port
    // and the ALU is stalled for that one cycle.
    assign force_ld = !fifo_empty && (starve_cnt >= STARVE_MAX);

    // Both ready signals depend only on registered state plus rst_n, so
    // upstream valid never loops back into ready. Holding them low during
    // reset keeps every output quiet while rst_n is asserted.
    assign alu_ready = rst_n && !force_ld;
    assign ld_ready  = rst_n && !fifo_full;

    assign alu_fire = alu_valid && alu_ready;
    assign ld_push  = ld_valid && ld_ready;

    // The head is written when it is forced or when the ALU has nothing to
    // offer; alu_fire and ld_pop are therefore mutually exclusive.
    assign ld_pop = rst_n && !fifo_empty && (force_ld || !alu_valid);

    // FIFO pointers, occupancy and the starvation counter. A push is never
    // possible with the FIFO full because ld_ready is already low, so the
    // occupancy cannot overflow even with a simultaneous push and pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            starve_cnt <= '0;
        end else begin
            if (ld_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (ld_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({ld_push, ld_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            // Counts cycles in which a waiting head lost to the ALU. The
            // force condition stalls the ALU before the counter can pass
            // STARVE_MAX, so no saturation logic is needed.
            if (ld_pop || fifo_empty) begin
                starve_cnt <= '0;
            end else if (alu_fire) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // FIFO payload needs no reset: occupancy alone decides validity, and
    // ld_push is already gated off while rst_n is low.
    always_ff @(posedge clk) begin
        if (ld_push) begin
            fifo_rd[wr_ptr]   <= ld_rd;
            fifo_data[wr_ptr] <= ld_data;
        end
    end

    // Writeback register. Results aimed at x0 still complete their
    // handshake and refresh the address/data, but never assert the enable.
    // On idle cycles address and data keep their previous values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_wa <= 5'd0;
            rf_wd <= '0;
        end else if (ld_pop) begin
            rf_we <= (head_rd != 5'd0);
            rf_wa <= head_rd;
            rf_wd <= head_data;
        end else if (alu_fire) begin
            rf_we <= (alu_rd != 5'd0);
            rf_wa <= alu_rd;
            rf_wd <= alu_data;
        end else begin
            rf_we <= 1'b0;
        end
    end

`ifdef WB_ARBITER_SCOREBOARD_EN
    logic [31:0] busy_q;
    logic [31:0] busy_next;

    // Clear first, then set, so a re-issue to a register whose earlier load
    // is being written in the same cycle leaves that register busy. ALU
    // writes never touch these flags.
    always_comb begin
        busy_next = busy_q;
        if (ld_pop) begin
            busy_next[head_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_next;
        end
    end

    assign busy = busy_q;
`else
    // Issue information is meaningless without the scoreboard; the name
    // marks the sink as intentionally unused.
    logic unused_iss;
    assign unused_iss = ^{iss_valid, iss_rd};
    assign busy       = 32'd0;
`endif

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the execute/memory stages and the register file write port. Merges two result streams, single-cycle ALU results and variable-latency load results, into the single write port (`we`/`wa`/`wd`). Load results are buffered in a 2-entry FIFO. A pending-load scoreboard feeds the hazard unit in decode.

## Interface
- `STARVE_LIMIT`, default 4: consecutive cycles a waiting load may lose arbitration before it is forced through.
- `XLEN`, default 32: data width.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low (already decided).
- `alu_valid`  in  1  ALU result present.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `alu_rd`  in  5  destination register.
- `alu_data`  in  XLEN  result.
- `ld_valid`  in  1  load result present.
- `ld_ready`  out  1  load FIFO can accept.
- `ld_rd`  in  5  load destination.
- `ld_data`  in  XLEN  load data.
- `iss_valid`  in  1  load issued to memory this cycle; marks `iss_rd` busy.
- `iss_rd`  in  5  issued load's destination.
- `rf_we`  out  1  register file write enable (registered).
- `rf_wa`  out  5  write address (registered).
- `rf_wd`  out  XLEN  write data (registered).
- `busy`  out  32  per-register pending-load flags; bit 0 always 0.

## Operation
- Load channel: a transfer occurs when `ld_valid & ld_ready`; the entry is pushed into a 2-entry FIFO. `ld_ready = (count < 2)`, from registered count only, with no combinational path from `ld_valid`.
- Arbitration each cycle between the ALU input and the FIFO head:
  - Default: the ALU wins. `alu_ready = 1` unless the starve counter forces the load.
  - Starve counter: increments when the FIFO is non-empty and the ALU wins; clears when the head is written or the FIFO is empty.
  - When the counter reaches `STARVE_LIMIT`, `alu_ready = 0` for that cycle and the FIFO head is written.
  - FIFO empty: `alu_ready = 1`.
- Winner is registered onto `rf_we/rf_wa/rf_wd`. Idle cycle: `rf_we = 0`; `rf_wa`/`rf_wd` hold their previous values.
- `rd == 0` results are still consumed (handshake completes, FIFO pops) but `rf_we = 0`.
- Simultaneous FIFO push and pop: count is unchanged; the push is allowed when count = 2 only if `ld_ready` was already high, i.e. it never is.
- Scoreboard:
  - Set `busy[iss_rd]` on `iss_valid` (`iss_rd != 0`).
  - Clear `busy[rd]` in the cycle a load result for `rd` is written (registered with `rf_we`).
  - Same-cycle set and clear of the same register: set wins.
  - ALU writes never clear busy bits.

## Timing
- Reset values: `rf_we = 0`, `rf_wa = 0`, `rf_wd = 0`, `busy = 0`, FIFO empty, starve counter 0, `ld_ready = 0` while `rst_n = 0` and 1 in the first cycle after release.
- Latency: accepted ALU result appears on `rf_*` 1 cycle later. A load accepted into an empty FIFO with no competing ALU appears 2 cycles after acceptance: push in cycle N, head arbitrated in N+1, `rf_*` valid in N+2.
- The register file samples on the falling edge, so `rf_*` are stable for the half cycle before capture.
- Reset asserted mid-operation: FIFO contents and busy bits are discarded, with no write issued. In-flight loads must be flushed by the memory unit.
- `busy` reflects registered state and updates one cycle after `iss_valid` or the write.

## Configuration
- `WB_ARBITER_SCOREBOARD_EN` defined: scoreboard as described.
- Undefined: no scoreboard flops, `busy` tied to 0, and `iss_valid`/`iss_rd` ignored. Decode must then stall on every load.

## Test plan
- Reset release: `rst_n` low 3 cycles, then high. Required: all outputs 0 during reset; `ld_ready = 1` on the first post-reset cycle.
- ALU-only: `alu_valid = 1`, `alu_rd = 5`, `alu_data = 0x1234`. Required: `rf_we = 1`, `rf_wa = 5`, `rf_wd = 0x1234` next cycle. Then `alu_rd = 0`, which must give `rf_we = 0`.
- FIFO full: two loads (`rd` 3 and 4) pushed with the ALU continuously valid. Required: `ld_ready = 0` after the second push.
- Starvation: same stimulus as the FIFO-full scenario, `STARVE_LIMIT = 4`. Required: `alu_ready = 0` in the 5th cycle and load `rd = 3` written the next cycle.
- Scoreboard: `iss_valid` with `iss_rd = 7` sets `busy[7]`. The load for `rd = 7` is later written, clearing `busy[7]`. In a separate case, a same-cycle write to 7 and re-issue to 7 must leave `busy[7] = 1`.
- Reset mid-operation: assert reset with 2 FIFO entries and `busy = 0x88`. Required: no `rf_we` pulse, `busy = 0`, FIFO empty after release.
